// File: rtl/div_pkg.sv
// Shared definitions for the divider arbiter: FSM states, response error codes, default width.
package div_pkg;

    localparam int DEF_W = 8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RESP      = 3'd4
    } state_t;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_DVZ = 2'b01;
    localparam logic [1:0] ERR_OVF = 2'b10;
    localparam logic [1:0] ERR_TMO = 2'b11;

endpackage

// File: rtl/div_arbiter_if.sv
// Bundle of requester-side and divider-side signals around div_arbiter.
// master = the arbiter; slave = the requesters plus the divider unit.
interface div_arbiter_if #(
    parameter int N = 4,
    parameter int W = div_pkg::DEF_W
);
    logic [N-1:0]   req;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   gnt;
    logic [N-1:0]   resp_valid;
    logic [W-1:0]   resp_q;
    logic [W-1:0]   resp_r;
    logic [1:0]     resp_err;
    logic           div_start;
    logic [W-1:0]   div_a;
    logic [W-1:0]   div_b;
    logic           div_busy;
    logic           div_valid;
    logic           div_dvz;
    logic           div_ovf;
    logic [W-1:0]   div_q;
    logic [W-1:0]   div_r;
    logic           arb_busy;

    modport master (
        input  req, req_a, req_b, div_busy, div_valid, div_dvz, div_ovf, div_q, div_r,
        output gnt, resp_valid, resp_q, resp_r, resp_err, div_start, div_a, div_b, arb_busy
    );

    modport slave (
        output req, req_a, req_b, div_busy, div_valid, div_dvz, div_ovf, div_q, div_r,
        input  gnt, resp_valid, resp_q, resp_r, resp_err, div_start, div_a, div_b, arb_busy
    );
endinterface

// File: rtl/div_arbiter_rr_picker.sv
// Combinational round-robin selector: first set req bit at or after ptr, wrapping at N.
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);
    localparam logic [PW:0] NV = (PW + 1)'(N);

    always_comb begin
        logic [PW:0] pos;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int i = 0; i < N; i++) begin
            pos = {1'b0, ptr} + (PW + 1)'(i);
            if (pos >= NV) pos = pos - NV;
            if (!any && req[pos[PW-1:0]]) begin
                any               = 1'b1;
                gnt[pos[PW-1:0]]  = 1'b1;
                idx               = pos[PW-1:0];
            end
        end
    end
endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one sequential divider among N requesters.
// Optional watchdog enabled by defining DIV_ARB_TIMEOUT_EN (limit TMO cycles).
module div_arbiter
    import div_pkg::*;
#(
    parameter int N   = 4,
    parameter int W   = DEF_W,
    parameter int TMO = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    div_arbiter_if.master bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    if (N < 2 || N > 8 || TMO < 1) begin : g_bad_params
        $error("div_arbiter: N must be 2..8 and TMO >= 1");
    end

    state_t          state, state_n;
    logic [PW-1:0]   ptr, owner, pick_idx;
    logic [N-1:0]    pick_gnt, gnt_c;
    logic            pick_any;
    logic [W-1:0]    op_a, op_b, sel_a, sel_b, res_q, res_r;
    logic [1:0]      res_err;
    logic            take, cap_ok, cap_abort, cap_tmo, tmo_hit;

    rr_picker #(.N(N), .PW(PW)) u_pick (
        .req (bus.req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_idx == PW'(i)) begin
                sel_a = bus.req_a[i*W +: W];
                sel_b = bus.req_b[i*W +: W];
            end
        end
    end

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TMO + 1);
    logic [CW-1:0] tmo_cnt;

    // Counts cycles spent waiting on the divider; restarts with every new grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (take) begin
            tmo_cnt <= '0;
        end else if (state == S_WAIT_BUSY || state == S_WAIT_DONE) begin
            tmo_cnt <= tmo_cnt + CW'(1);
        end
    end

    assign tmo_hit = (tmo_cnt == CW'(TMO - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        gnt_c     = '0;
        take      = 1'b0;
        cap_ok    = 1'b0;
        cap_abort = 1'b0;
        cap_tmo   = 1'b0;
        case (state)
            S_IDLE: begin
                if (pick_any) begin
                    gnt_c   = pick_gnt;
                    take    = 1'b1;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: state_n = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (bus.div_valid) begin
                    cap_ok  = 1'b1;
                    state_n = S_RESP;
                end else if (tmo_hit) begin
                    cap_tmo = 1'b1;
                    state_n = S_RESP;
                end else if (bus.div_busy) begin
                    state_n = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                // A result arriving as busy falls wins over the abort interpretation.
                if (bus.div_valid) begin
                    cap_ok  = 1'b1;
                    state_n = S_RESP;
                end else if (tmo_hit) begin
                    cap_tmo = 1'b1;
                    state_n = S_RESP;
                end else if (!bus.div_busy) begin
                    cap_abort = 1'b1;
                    state_n   = S_RESP;
                end
            end
            S_RESP:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            owner   <= '0;
            op_a    <= '0;
            op_b    <= '0;
            res_q   <= '0;
            res_r   <= '0;
            res_err <= ERR_OK;
        end else begin
            if (take) begin
                owner <= pick_idx;
                op_a  <= sel_a;
                op_b  <= sel_b;
            end
            if (cap_ok) begin
                res_q   <= bus.div_q;
                res_r   <= bus.div_r;
                res_err <= ERR_OK;
            end else if (cap_abort || cap_tmo) begin
                res_q   <= '0;
                res_r   <= '0;
                res_err <= cap_tmo ? ERR_TMO : (bus.div_dvz ? ERR_DVZ : ERR_OVF);
            end
            if (state == S_RESP) begin
                ptr <= (owner == PW'(N - 1)) ? '0 : owner + PW'(1);
            end
        end
    end

    assign bus.gnt        = gnt_c;
    assign bus.div_start  = (state == S_ISSUE);
    assign bus.div_a      = op_a;
    assign bus.div_b      = op_b;
    assign bus.resp_valid = (state == S_RESP) ? (N'(1) << owner) : '0;
    assign bus.resp_q     = res_q;
    assign bus.resp_r     = res_r;
    assign bus.resp_err   = res_err;
    assign bus.arb_busy   = (state != S_IDLE);
endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter; the bench plays both the requesters and the divider.
module tb_div_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    div_arbiter_if #(.N(4), .W(8)) bus ();

    div_arbiter #(.N(4), .W(8), .TMO(20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called while the DUT is in ISSUE; returns with the DUT in RESP.
    task automatic divider_done(input int busy_cyc, input logic vld, input logic dvz,
                                input logic ovf, input logic [7:0] q, input logic [7:0] r);
        tick();
        bus.div_busy = 1'b1;
        repeat (busy_cyc) tick();
        bus.div_valid = vld;
        bus.div_dvz   = dvz;
        bus.div_ovf   = ovf;
        bus.div_q     = q;
        bus.div_r     = r;
        bus.div_busy  = 1'b0;
        tick();
        bus.div_valid = 1'b0;
        bus.div_dvz   = 1'b0;
        bus.div_ovf   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req = '0; bus.req_a = '0; bus.req_b = '0;
        bus.div_busy = 1'b0; bus.div_valid = 1'b0; bus.div_dvz = 1'b0; bus.div_ovf = 1'b0;
        bus.div_q = '0; bus.div_r = '0;
        #3;
        checks++; if (bus.arb_busy !== 1'b0 || bus.div_start !== 1'b0) begin errors++; $display("FAIL reset_ctrl busy=%b start=%b expected 0 0", bus.arb_busy, bus.div_start); end
        checks++; if (bus.gnt !== 4'b0 || bus.resp_valid !== 4'b0) begin errors++; $display("FAIL reset_hs gnt=%b resp_valid=%b expected 0 0", bus.gnt, bus.resp_valid); end
        checks++; if (bus.div_a !== 8'd0 || bus.div_b !== 8'd0 || bus.resp_q !== 8'd0 || bus.resp_r !== 8'd0 || bus.resp_err !== 2'b00) begin errors++; $display("FAIL reset_data a=%h b=%h q=%h r=%h err=%b expected all 0", bus.div_a, bus.div_b, bus.resp_q, bus.resp_r, bus.resp_err); end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        checks++; if (bus.arb_busy !== 1'b0 || bus.gnt !== 4'b0) begin errors++; $display("FAIL reset_idle busy=%b gnt=%b expected 0 0000", bus.arb_busy, bus.gnt); end
    endtask

    task automatic test_single();
        bus.req = 4'b0010;
        bus.req_a[8 +: 8] = 8'd100;
        bus.req_b[8 +: 8] = 8'd7;
        #1;
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL single_gnt got %b expected 0010", bus.gnt); end
        tick();
        bus.req = '0;
        #1;
        checks++; if (bus.div_start !== 1'b1 || bus.gnt !== 4'b0) begin errors++; $display("FAIL single_start start=%b gnt=%b expected 1 0000", bus.div_start, bus.gnt); end
        checks++; if (bus.div_a !== 8'd100 || bus.div_b !== 8'd7) begin errors++; $display("FAIL single_ops a=%0d b=%0d expected 100 7", bus.div_a, bus.div_b); end
        tick();
        checks++; if (bus.div_start !== 1'b0 || bus.arb_busy !== 1'b1) begin errors++; $display("FAIL single_wait start=%b busy=%b expected 0 1", bus.div_start, bus.arb_busy); end
        bus.div_busy = 1'b1;
        repeat (3) tick();
        checks++; if (bus.div_a !== 8'd100 || bus.resp_valid !== 4'b0) begin errors++; $display("FAIL single_hold a=%0d resp_valid=%b expected 100 0000", bus.div_a, bus.resp_valid); end
        bus.div_valid = 1'b1; bus.div_q = 8'd14; bus.div_r = 8'd2; bus.div_busy = 1'b0;
        tick();
        bus.div_valid = 1'b0;
        checks++; if (bus.resp_valid !== 4'b0010) begin errors++; $display("FAIL single_rv got %b expected 0010", bus.resp_valid); end
        checks++; if (bus.resp_q !== 8'd14 || bus.resp_r !== 8'd2 || bus.resp_err !== 2'b00) begin errors++; $display("FAIL single_res q=%0d r=%0d err=%b expected 14 2 00", bus.resp_q, bus.resp_r, bus.resp_err); end
        tick();
        checks++; if (bus.resp_valid !== 4'b0 || bus.resp_q !== 8'd14 || bus.arb_busy !== 1'b0) begin errors++; $display("FAIL single_after rv=%b q=%0d busy=%b expected 0000 14 0", bus.resp_valid, bus.resp_q, bus.arb_busy); end
    endtask

    task automatic test_errors();
        bus.req = 4'b0001;
        bus.req_a[0 +: 8] = 8'd5;
        bus.req_b[0 +: 8] = 8'd0;
        #1;
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL dvz_gnt got %b expected 0001", bus.gnt); end
        tick();
        bus.req = '0;
        divider_done(2, 1'b0, 1'b1, 1'b0, 8'hAA, 8'h55);
        checks++; if (bus.resp_valid !== 4'b0001 || bus.resp_err !== 2'b01) begin errors++; $display("FAIL dvz_resp rv=%b err=%b expected 0001 01", bus.resp_valid, bus.resp_err); end
        checks++; if (bus.resp_q !== 8'd0 || bus.resp_r !== 8'd0) begin errors++; $display("FAIL dvz_zero q=%h r=%h expected 00 00", bus.resp_q, bus.resp_r); end
        tick();
        bus.req = 4'b0010;
        bus.req_a[8 +: 8] = 8'd200;
        bus.req_b[8 +: 8] = 8'd1;
        #1;
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL ovf_gnt got %b expected 0010", bus.gnt); end
        tick();
        bus.req = '0;
        divider_done(1, 1'b0, 1'b0, 1'b1, 8'h33, 8'h44);
        checks++; if (bus.resp_valid !== 4'b0010 || bus.resp_err !== 2'b10 || bus.resp_q !== 8'd0) begin errors++; $display("FAIL ovf_resp rv=%b err=%b q=%h expected 0010 10 00", bus.resp_valid, bus.resp_err, bus.resp_q); end
        tick();
    endtask

    task automatic test_fairness();
        logic [3:0] exp_order [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                      4'b0001, 4'b0010, 4'b0100, 4'b1000};
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.req_a[i*8 +: 8] = 8'(10 + i);
            bus.req_b[i*8 +: 8] = 8'd1;
        end
        bus.req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            int w;
            w = k % 4;
            if (k == 4) bus.req = 4'b1111;
            #1;
            checks++; if (bus.gnt !== exp_order[k]) begin errors++; $display("FAIL fair_gnt[%0d] got %b expected %b", k, bus.gnt, exp_order[k]); end
            tick();
            bus.req[w] = 1'b0;
            checks++; if (bus.div_a !== 8'(10 + w)) begin errors++; $display("FAIL fair_op[%0d] got %0d expected %0d", k, bus.div_a, 10 + w); end
            divider_done(1, 1'b1, 1'b0, 1'b0, 8'(10 + w), 8'd0);
            checks++; if (bus.resp_valid !== exp_order[k] || bus.resp_q !== 8'(10 + w)) begin errors++; $display("FAIL fair_resp[%0d] rv=%b q=%0d expected %b %0d", k, bus.resp_valid, bus.resp_q, exp_order[k], 10 + w); end
            tick();
        end
    endtask

    task automatic test_contention();
        bus.req = 4'b0001;
        bus.req_a[0 +: 8] = 8'd20;
        bus.req_b[0 +: 8] = 8'd3;
        #1;
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL cont_gnt0 got %b expected 0001", bus.gnt); end
        tick();
        bus.req = '0;
        tick();
        bus.div_busy = 1'b1;
        bus.req = 4'b0100;
        bus.req_a[16 +: 8] = 8'd9;
        bus.req_b[16 +: 8] = 8'd4;
        #1;
        checks++; if (bus.gnt !== 4'b0) begin errors++; $display("FAIL cont_nognt_busy got %b expected 0000", bus.gnt); end
        tick();
        checks++; if (bus.gnt !== 4'b0) begin errors++; $display("FAIL cont_nognt_done got %b expected 0000", bus.gnt); end
        bus.div_valid = 1'b1; bus.div_q = 8'd6; bus.div_r = 8'd2; bus.div_busy = 1'b0;
        tick();
        bus.div_valid = 1'b0;
        checks++; if (bus.resp_valid !== 4'b0001 || bus.gnt !== 4'b0 || bus.resp_q !== 8'd6) begin errors++; $display("FAIL cont_resp0 rv=%b gnt=%b q=%0d expected 0001 0000 6", bus.resp_valid, bus.gnt, bus.resp_q); end
        tick();
        checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL cont_gnt2 got %b expected 0100", bus.gnt); end
        tick();
        bus.req = '0;
        divider_done(0, 1'b1, 1'b0, 1'b0, 8'd2, 8'd1);
        checks++; if (bus.resp_valid !== 4'b0100 || bus.resp_q !== 8'd2 || bus.resp_r !== 8'd1) begin errors++; $display("FAIL cont_resp2 rv=%b q=%0d r=%0d expected 0100 2 1", bus.resp_valid, bus.resp_q, bus.resp_r); end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.req = 4'b1000;
        bus.req_a[24 +: 8] = 8'd9;
        bus.req_b[24 +: 8] = 8'd2;
        #1;
        checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL rmid_gnt got %b expected 1000", bus.gnt); end
        tick();
        bus.req = '0;
        tick();
        bus.div_busy = 1'b1;
        tick();
        rst_n = 1'b0;
        bus.div_busy = 1'b0;
        #1;
        checks++; if (bus.arb_busy !== 1'b0 || bus.div_a !== 8'd0 || bus.div_b !== 8'd0 || bus.resp_q !== 8'd0 || bus.resp_err !== 2'b00) begin errors++; $display("FAIL rmid_clear busy=%b a=%h b=%h q=%h err=%b expected all 0", bus.arb_busy, bus.div_a, bus.div_b, bus.resp_q, bus.resp_err); end
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (bus.resp_valid !== 4'b0) begin errors++; $display("FAIL rmid_norv[%0d] got %b expected 0000", c, bus.resp_valid); end
        end
        rst_n = 1'b1;
        tick();
        checks++; if (bus.resp_valid !== 4'b0 || bus.arb_busy !== 1'b0) begin errors++; $display("FAIL rmid_idle rv=%b busy=%b expected 0000 0", bus.resp_valid, bus.arb_busy); end
        bus.req = 4'b1010;
        bus.req_a[8 +: 8] = 8'd50;
        bus.req_b[8 +: 8] = 8'd5;
        #1;
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL rmid_ptr0 got %b expected 0010", bus.gnt); end
        tick();
        bus.req = '0;
        divider_done(2, 1'b1, 1'b0, 1'b0, 8'd10, 8'd0);
        checks++; if (bus.resp_valid !== 4'b0010 || bus.resp_q !== 8'd10 || bus.resp_err !== 2'b00) begin errors++; $display("FAIL rmid_resp rv=%b q=%0d err=%b expected 0010 10 00", bus.resp_valid, bus.resp_q, bus.resp_err); end
        tick();
    endtask

`ifdef DIV_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        bus.req = 4'b0100;
        bus.req_a[16 +: 8] = 8'd1;
        bus.req_b[16 +: 8] = 8'd1;
        #1;
        checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL tmo_gnt got %b expected 0100", bus.gnt); end
        tick();
        bus.req = '0;
        tick();
        bus.div_busy = 1'b1;
        n = 0;
        while (bus.resp_valid === 4'b0 && n < 100) begin
            tick();
            n++;
        end
        checks++; if (n !== 20) begin errors++; $display("FAIL tmo_latency got %0d cycles expected 20", n); end
        checks++; if (bus.resp_valid !== 4'b0100 || bus.resp_err !== 2'b11 || bus.resp_q !== 8'd0 || bus.resp_r !== 8'd0) begin errors++; $display("FAIL tmo_resp rv=%b err=%b q=%h r=%h expected 0100 11 00 00", bus.resp_valid, bus.resp_err, bus.resp_q, bus.resp_r); end
        bus.div_busy = 1'b0;
        tick();
    endtask
`else
    task automatic test_timeout();
        int seen;
        bus.req = 4'b0100;
        bus.req_a[16 +: 8] = 8'd1;
        bus.req_b[16 +: 8] = 8'd1;
        #1;
        checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL notmo_gnt got %b expected 0100", bus.gnt); end
        tick();
        bus.req = '0;
        tick();
        bus.div_busy = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus.resp_valid !== 4'b0 || bus.arb_busy !== 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL notmo_wait early responses=%0d expected 0", seen); end
        bus.div_valid = 1'b1; bus.div_q = 8'd1; bus.div_r = 8'd0; bus.div_busy = 1'b0;
        tick();
        bus.div_valid = 1'b0;
        checks++; if (bus.resp_valid !== 4'b0100 || bus.resp_err !== 2'b00 || bus.resp_q !== 8'd1) begin errors++; $display("FAIL notmo_resp rv=%b err=%b q=%0d expected 0100 00 1", bus.resp_valid, bus.resp_err, bus.resp_q); end
        tick();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_errors();
        test_fairness();
        test_contention();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
